// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared definitions for the display counter controller.
//   - cmd_op_e : command opcodes carried on cmd_op
//   - state_e  : controller states
//   - default counter/divider widths and divider limits for a 50 MHz clock
package count_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned DIV_W_DEF = 28;

  // Divider limits: a tick occurs every (limit + 1) clock cycles.
  localparam logic [27:0] RATE0_DEF = 28'd0;            // every cycle
  localparam logic [27:0] RATE1_DEF = 28'd49_999_999;   // 1 Hz
  localparam logic [27:0] RATE2_DEF = 28'd99_999_999;   // 0.5 Hz
  localparam logic [27:0] RATE3_DEF = 28'd199_999_999;  // 0.25 Hz

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_LOAD     = 2'b01,
    OP_SET_RATE = 2'b10,
    OP_RUNSTOP  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    STOP     = 2'b00,
    RUN      = 2'b01,
    RELOAD_S = 2'b10,
    RELOAD_R = 2'b11
  } state_e;

  // Commands are only taken in the two steady states.
  function automatic logic is_ready(input state_e s);
    return (s == STOP) || (s == RUN);
  endfunction

endpackage

// File: rtl/count_ctrl_tick.sv
// rate_tick: shared down-counter divider.
//   clk, reset_b : clock, async active-low reset
//   en           : count this cycle (decrement, or reload on reaching zero)
//   reload       : load limit unconditionally (wins over en)
//   limit        : currently selected divider limit
//   zero         : counter is at zero (divider period elapsed)
module rate_tick
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             en,
  input  logic             reload,
  input  logic [DIV_W-1:0] limit,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= limit;
    end else if (en) begin
      cnt <= zero ? limit : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: controller for the rate-divided display counter.
//   clk       : system clock
//   reset_b   : async active-low reset
//   cmd_valid : command offered
//   cmd_ready : command accepted this cycle if valid (STOP/RUN only)
//   cmd_op    : 00 CLEAR, 01 LOAD, 10 SET_RATE, 11 RUNSTOP
//   cmd_data  : LOAD value / rate select in [1:0] / run(1)/stop(0) in [0]
//   q         : counter value (registered)
//   tick      : pulse on each increment of q
//   wrap      : pulse on a tick-driven 15 -> 0 transition
//   running   : high in RUN, and in RELOAD_R
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W = CNT_W_DEF,
  parameter int unsigned      DIV_W = DIV_W_DEF,
  parameter logic [DIV_W-1:0] RATE0 = DIV_W'(RATE0_DEF),
  parameter logic [DIV_W-1:0] RATE1 = DIV_W'(RATE1_DEF),
  parameter logic [DIV_W-1:0] RATE2 = DIV_W'(RATE2_DEF),
  parameter logic [DIV_W-1:0] RATE3 = DIV_W'(RATE3_DEF)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  output logic [CNT_W-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             running
);

  state_e           state;
  logic [1:0]       rate_sel;
  logic [DIV_W-1:0] limit;
  cmd_op_e          op;
  logic             accept;
  logic             run_cmd;
  logic             run_noop;
  logic             div_en;
  logic             div_reload;
  logic             div_zero;
  logic             inc;

  assign cmd_ready = is_ready(state);
  assign accept    = cmd_valid & cmd_ready;
  assign op        = cmd_op_e'(cmd_op);
  assign run_cmd   = (op == OP_RUNSTOP) & cmd_data[0];

  always_comb begin
    limit = RATE0;
    unique case (rate_sel)
      2'd0: limit = RATE0;
      2'd1: limit = RATE1;
      2'd2: limit = RATE2;
      2'd3: limit = RATE3;
    endcase
  end

  // RUNSTOP-run while already running changes nothing, so the divider keeps
  // its phase and a coincident tick is still delivered.
  assign run_noop = accept & run_cmd & (state == RUN);

  assign div_en = (state == RUN) & (~accept | run_noop);

  assign div_reload = (state == RELOAD_S) || (state == RELOAD_R) ||
                      (accept && ((op == OP_CLEAR) || (op == OP_LOAD) ||
                                  (run_cmd && (state == STOP))));

  assign inc = div_en & div_zero;

  rate_tick #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset_b (reset_b),
    .en      (div_en),
    .reload  (div_reload),
    .limit   (limit),
    .zero    (div_zero)
  );

  // inc and a state-changing accept are mutually exclusive, so the command
  // branch below never has to override an increment.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= STOP;
      rate_sel <= 2'd0;
      q        <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      running  <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;

      if (inc) begin
        q    <= q + CNT_W'(1);
        tick <= 1'b1;
        wrap <= (q == '1);
      end

      unique case (state)
        STOP, RUN: begin
          if (accept) begin
            unique case (op)
              OP_CLEAR: q <= '0;
              OP_LOAD:  q <= cmd_data;
              OP_SET_RATE: begin
                rate_sel <= cmd_data[1:0];
                state    <= (state == RUN) ? RELOAD_R : RELOAD_S;
                running  <= (state == RUN);
              end
              OP_RUNSTOP: begin
                if (cmd_data[0]) begin
                  state   <= RUN;
                  running <= 1'b1;
                end else begin
                  state   <= STOP;
                  running <= 1'b0;
                end
              end
            endcase
          end
        end
        RELOAD_S: begin
          state   <= STOP;
          running <= 1'b0;
        end
        RELOAD_R: begin
          state   <= RUN;
          running <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: self-checking bench for count_ctrl with shortened rates
// (0, 3, 5, 7). Directed scenarios plus a randomized run against a
// cycle-level behavioural model.
module tb_count_ctrl;

  localparam logic [1:0] C_CLEAR = 2'b00;
  localparam logic [1:0] C_LOAD  = 2'b01;
  localparam logic [1:0] C_RATE  = 2'b10;
  localparam logic [1:0] C_RUNST = 2'b11;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [3:0] q;
  logic       tick;
  logic       wrap;
  logic       running;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  count_ctrl #(
    .CNT_W (4),
    .DIV_W (28),
    .RATE0 (28'd0),
    .RATE1 (28'd3),
    .RATE2 (28'd5),
    .RATE3 (28'd7)
  ) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .q         (q),
    .tick      (tick),
    .wrap      (wrap),
    .running   (running)
  );

  // ---------------- behavioural model ----------------
  localparam int M_STOP = 0, M_RUN = 1, M_REL_S = 2, M_REL_R = 3;
  int unsigned rates [4] = '{0, 3, 5, 7};
  int m_q, m_wait, m_sel, m_mode;
  bit m_tick, m_wrap, m_running;

  function automatic bit m_ready();
    return (m_mode == M_STOP) || (m_mode == M_RUN);
  endfunction

  task automatic model_reset();
    m_q = 0; m_wait = 0; m_sel = 0; m_mode = M_STOP;
    m_tick = 0; m_wrap = 0; m_running = 0;
  endtask

  // m_wait = cycles still to elapse before the next tick while running.
  task automatic model_edge(input bit valid, input int op, input int data);
    bit acc, is_run, noop;
    acc    = valid && m_ready();
    is_run = (op == 3) && ((data % 2) == 1);
    noop   = acc && is_run && (m_mode == M_RUN);
    m_tick = 0;
    m_wrap = 0;
    if (m_mode == M_REL_S) begin
      m_wait = rates[m_sel]; m_mode = M_STOP;
    end else if (m_mode == M_REL_R) begin
      m_wait = rates[m_sel]; m_mode = M_RUN;
    end else if (acc && !noop) begin
      case (op)
        0: begin m_q = 0; m_wait = rates[m_sel]; end
        1: begin m_q = data % 16; m_wait = rates[m_sel]; end
        2: begin
          m_sel  = data % 4;
          m_mode = (m_mode == M_RUN) ? M_REL_R : M_REL_S;
        end
        default: begin
          if (is_run) begin m_mode = M_RUN; m_wait = rates[m_sel]; end
          else m_mode = M_STOP;
        end
      endcase
    end else if (m_mode == M_RUN) begin
      if (m_wait == 0) begin
        m_tick = 1;
        m_wrap = (m_q == 15);
        m_q    = (m_q + 1) % 16;
        m_wait = rates[m_sel];
      end else begin
        m_wait = m_wait - 1;
      end
    end
    m_running = (m_mode == M_RUN) || (m_mode == M_REL_R);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    reset_b   = 1'b0;
    cycle();
    cycle();
    reset_b = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data);
    int unsigned waited = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
    end
    cycle();
    cmd_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_b = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
    #3 reset_b = 1'b0;
    #1;
    vectors++; if (q !== 4'h0)       begin errors++; $display("FAIL reset_q: got %h required 0", q); end
    vectors++; if (tick !== 1'b0)    begin errors++; $display("FAIL reset_tick: got %b required 0", tick); end
    vectors++; if (wrap !== 1'b0)    begin errors++; $display("FAIL reset_wrap: got %b required 0", wrap); end
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b required 0", running); end
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cmd_ready); end
    cycle();
    reset_b = 1'b1;
    cycle();
    vectors++; if (q !== 4'h0 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_idle: q=%h tick=%b required q=0 tick=0", q, tick);
    end
  endtask

  task automatic test_count_rate0();
    do_reset();
    send(C_RUNST, 4'h1);
    vectors++; if (running !== 1'b1 || q !== 4'h0 || tick !== 1'b0) begin
      errors++; $display("FAIL run_start: running=%b q=%h tick=%b required 1 0 0", running, q, tick);
    end
    for (int i = 1; i <= 17; i++) begin
      cycle();
      vectors++; if (q !== 4'(i % 16) || tick !== 1'b1 || wrap !== (i == 16)) begin
        errors++;
        $display("FAIL count_rate0[%0d]: q=%h tick=%b wrap=%b required q=%h tick=1 wrap=%b",
                 i, q, tick, wrap, 4'(i % 16), (i == 16));
      end
    end
  endtask

  task automatic test_rate_select();
    do_reset();
    send(C_RATE, 4'h1);
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rate_reload_ready: got %b required 0", cmd_ready); end
    cycle();
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rate_after_reload_ready: got %b required 1", cmd_ready); end
    send(C_RUNST, 4'h1);
    for (int j = 1; j <= 8; j++) begin
      cycle();
      vectors++; if (tick !== ((j % 4) == 0)) begin
        errors++; $display("FAIL rate1_tick[%0d]: got %b required %b", j, tick, ((j % 4) == 0));
      end
    end
    vectors++; if (q !== 4'h2) begin errors++; $display("FAIL rate1_q: got %h required 2", q); end
  endtask

  task automatic test_load_on_tick();
    do_reset();
    send(C_RUNST, 4'h1);
    cycle(); cycle(); cycle();
    cmd_valid = 1'b1; cmd_op = C_LOAD; cmd_data = 4'hE;
    cycle();
    cmd_valid = 1'b0;
    vectors++; if (q !== 4'hE || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_wins: q=%h tick=%b wrap=%b required E 0 0", q, tick, wrap);
    end
    cycle();
    vectors++; if (q !== 4'hF || tick !== 1'b1 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_next: q=%h tick=%b wrap=%b required F 1 0", q, tick, wrap);
    end
    cycle();
    vectors++; if (q !== 4'h0 || tick !== 1'b1 || wrap !== 1'b1) begin
      errors++; $display("FAIL load_wrap: q=%h tick=%b wrap=%b required 0 1 1", q, tick, wrap);
    end
    cycle();
    vectors++; if (q !== 4'h1 || wrap !== 1'b0) begin
      errors++; $display("FAIL after_wrap: q=%h wrap=%b required 1 0", q, wrap);
    end
  endtask

  task automatic test_stop_resume();
    do_reset();
    send(C_RATE, 4'h1);
    cycle();
    send(C_LOAD, 4'h7);
    send(C_RUNST, 4'h1);
    cycle();
    vectors++; if (dut.u_div.cnt !== 28'd2) begin
      errors++; $display("FAIL div_before_stop: got %0d required 2", dut.u_div.cnt);
    end
    send(C_RUNST, 4'h0);
    vectors++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b required 0", running); end
    for (int j = 0; j < 10; j++) begin
      cycle();
      vectors++; if (q !== 4'h7 || tick !== 1'b0) begin
        errors++; $display("FAIL frozen[%0d]: q=%h tick=%b required 7 0", j, q, tick);
      end
    end
    vectors++; if (dut.u_div.cnt !== 28'd2) begin
      errors++; $display("FAIL div_frozen: got %0d required 2", dut.u_div.cnt);
    end
    send(C_RUNST, 4'h1);
    for (int j = 1; j <= 4; j++) begin
      cycle();
      vectors++; if (tick !== (j == 4)) begin
        errors++; $display("FAIL resume_tick[%0d]: got %b required %b", j, tick, (j == 4));
      end
    end
    vectors++; if (q !== 4'h8) begin errors++; $display("FAIL resume_q: got %h required 8", q); end
  endtask

  task automatic test_hold_through_reload();
    do_reset();
    cmd_valid = 1'b1; cmd_op = C_RATE; cmd_data = 4'h0;
    cycle();
    cmd_op = C_LOAD; cmd_data = 4'h5;
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_low: got %b required 0", cmd_ready); end
    cycle();
    vectors++; if (q !== 4'h0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL hold_not_taken: q=%h ready=%b required 0 1", q, cmd_ready);
    end
    cycle();
    cmd_valid = 1'b0;
    vectors++; if (q !== 4'h5 || tick !== 1'b0) begin
      errors++; $display("FAIL hold_taken: q=%h tick=%b required 5 0", q, tick);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    send(C_RUNST, 4'h1);
    for (int j = 0; j < 9; j++) cycle();
    vectors++; if (q !== 4'h9) begin errors++; $display("FAIL midrun_q: got %h required 9", q); end
    #2 reset_b = 1'b0;
    #1;
    vectors++; if (q !== 4'h0 || running !== 1'b0 || cmd_ready !== 1'b1 || tick !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: q=%h running=%b ready=%b tick=%b required 0 0 1 0",
                         q, running, cmd_ready, tick);
    end
    #2 reset_b = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cycle();
      vectors++; if (q !== 4'h0 || tick !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle[%0d]: q=%h tick=%b required 0 0", j, q, tick);
      end
    end
    send(C_RUNST, 4'h1);
    cycle();
    vectors++; if (tick !== 1'b1 || q !== 4'h1) begin
      errors++; $display("FAIL post_reset_run: tick=%b q=%h required 1 1", tick, q);
    end
  endtask

  task automatic test_random(input int unsigned n);
    bit pending = 0;
    do_reset();
    model_reset();
    for (int unsigned i = 0; i < n; i++) begin
      if (!pending) begin
        cmd_valid = ($urandom_range(0, 3) == 0);
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 4'($urandom_range(0, 15));
        if (cmd_op == C_RUNST) cmd_data[0] = ($urandom_range(0, 3) != 0);
      end
      vectors++; if (cmd_ready !== m_ready()) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b required %b", i, cmd_ready, m_ready());
      end
      pending = cmd_valid && !m_ready();
      model_edge(cmd_valid, int'(cmd_op), int'(cmd_data));
      cycle();
      vectors++; if (q !== 4'(m_q) || tick !== m_tick || wrap !== m_wrap || running !== m_running) begin
        errors++;
        $display("FAIL rnd_out[%0d]: q=%h tick=%b wrap=%b running=%b required q=%h tick=%b wrap=%b running=%b",
                 i, q, tick, wrap, running, 4'(m_q), m_tick, m_wrap, m_running);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_count_rate0();
    test_rate_select();
    test_load_on_tick();
    test_stop_resume();
    test_hold_through_reload();
    test_reset_midrun();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Controller for the rate-divided 4-bit display counter. It owns one shared 28-bit down-counter divider and the counter value. It accepts clear, load, rate-select and run/stop commands over a valid/ready handshake, and emits the counter value, a tick pulse and a wrap pulse. It sits between the switch/command source and the hex display decoder, and replaces ad-hoc parallel dividers and priority logic.

Parameters:
CNT_W, 4, counter width.
DIV_W, 28, divider width.
RATE0, 0, divider limit for rate select 0 (tick every cycle).
RATE1, 28'd49_999_999, limit for rate select 1 (1 Hz at 50 MHz).
RATE2, 28'd99_999_999, limit for rate select 2 (0.5 Hz).
RATE3, 28'd199_999_999, limit for rate select 3 (0.25 Hz).

Ports:
clk  input  1  system clock (CLOCK_50 domain), single clock.
reset_b  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  command can be accepted this cycle.
cmd_op  input  2  00 CLEAR, 01 LOAD, 10 SET_RATE, 11 RUNSTOP.
cmd_data  input  CNT_W  LOAD value; [1:0] = rate select for SET_RATE; [0] = 1 run / 0 stop for RUNSTOP.
q  output  CNT_W  counter value, registered.
tick  output  1  one-cycle pulse, coincident with each increment of q.
wrap  output  1  one-cycle pulse, coincident with the q transition from 15 to 0 caused by a tick.
running  output  1  high in RUN, and in RELOAD when returning to RUN.

Behaviour:
- Reset (async assert, sync release): q=0, div_cnt=0, rate_sel=0, state=STOP, tick=0, wrap=0, running=0. cmd_ready=1 immediately.
- accept = cmd_valid & cmd_ready. A command takes effect at the accepting clock edge, so its result is visible the following cycle.
- States: STOP, RUN, RELOAD_S, RELOAD_R. cmd_ready=1 in STOP and RUN, 0 in both RELOAD states.
- limit = RATE[rate_sel], selected by a 4-way mux.
- Divider in RUN with no accept: if div_cnt==0, reload to limit and raise inc. Otherwise decrement div_cnt.
- Divider in STOP: div_cnt holds and inc never fires.
- inc: q <= q+1 modulo 2^CNT_W; tick <= 1; wrap <= (q == all-ones). Both pulses are otherwise 0.
- q wraps only on inc. A held value of 15 never auto-clears.
- An accepted command always wins over a coincident inc. q takes the command's result and tick/wrap stay 0 on that edge.
- CLEAR: q <= 0; div_cnt <= limit (phase restart); state unchanged.
- LOAD: q <= cmd_data; div_cnt <= limit; state unchanged.
- SET_RATE: rate_sel <= cmd_data[1:0]; go to RELOAD_R if in RUN, else RELOAD_S. Accepted in either STOP or RUN.
- RELOAD_x (exactly 1 cycle): div_cnt <= new limit; no inc; then return to RUN or STOP respectively.
- RUNSTOP with data[0]=1: from STOP, go to RUN with div_cnt <= limit. In RUN it is a no-op, and div_cnt keeps counting.
- RUNSTOP with data[0]=0: go to STOP with div_cnt held.
- First tick after RUN is accepted at edge k arrives at edge k+limit+1.
- Reset asserted mid-operation (including in RELOAD): all state returns to reset values immediately, with no residual pulse.
- cmd_valid may stay high while cmd_ready=0. The command is held and accepted on the first ready cycle. Source obeys valid-stable-until-accepted.

Decomposition:
- Package count_ctrl_pkg holds the cmd_op encodings, the state enum (STOP, RUN, RELOAD_S, RELOAD_R) and the default RATE constants.
- One sub-module: rate_tick. It contains the down-counter with inputs en, reload, limit and output zero.
- count_ctrl keeps the FSM, the command decode and the q/tick/wrap registers.

Test Plan:
1. Reset, then RUNSTOP run (RATE0=0) → q counts 1,2,… every cycle with tick every cycle; wrap high exactly on the edge where q goes 15→0 (16th tick).
2. Bench RATE1=3: SET_RATE 1 from STOP, then RUNSTOP run → cmd_ready low for exactly one cycle after SET_RATE; ticks then occur every 4 cycles.
3. Running at RATE0, LOAD 0xE offered on a tick cycle → q=0xE with no tick that edge; next edges q=0xF, then q=0 with wrap=1.
4. Bench RATE1=3 running, RUNSTOP stop at div_cnt=2 → q and div_cnt frozen for 10 cycles with tick=0; RUNSTOP run → next tick after 4 cycles.
5. cmd_valid held with LOAD 5 through the RELOAD cycle → not accepted while cmd_ready=0; accepted next cycle, so q=5 one cycle later.
6. reset_b pulsed low mid-RUN at q=9, between clock edges → q=0, running=0, cmd_ready=1 immediately; no ticks after release until a RUNSTOP run is accepted.
